// File: rtl/regfile_pkg.sv
// Shared definitions for the 8x8 register file and its dump reader.
package regfile_pkg;

  localparam int REG_DATA_WIDTH = 8;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int REG_COUNT      = 8;

  // Also decoded by the controller's debug stall logic, so the encoding is fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } dump_state_t;

  // Running byte checksum: addition modulo 2**REG_DATA_WIDTH.
  function automatic logic [REG_DATA_WIDTH-1:0] sum_add(
    input logic [REG_DATA_WIDTH-1:0] acc,
    input logic [REG_DATA_WIDTH-1:0] val
  );
    return acc + val;
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready byte stream carrying register dump beats (value, address, last flag).
interface regfile_dump_reader_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Sweeps register file read port 1 over all addresses and streams each value.
// Optional DUMP_CHECKSUM_EN appends a modulo-256 checksum beat after the registers.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_REGS   = REG_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  regfile_dump_reader_if.master strm
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hs_s;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign hs_s = out_valid_q && strm.out_ready;

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          rd_addr_d = ADDR_ZERO;
          busy_d    = 1'b1;
`ifdef DUMP_CHECKSUM_EN
          sum_d     = DATA_ZERO;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        // rd_addr has been stable for the whole cycle, so RD1 is settled.
        out_data_d  = rd_data;
        out_addr_d  = rd_addr_q;
        out_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        sum_d       = sum_add(sum_q, rd_data);
`else
        out_last_d  = (rd_addr_q == LAST_ADDR);
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (rd_addr_q == LAST_ADDR) begin
`ifdef DUMP_CHECKSUM_EN
            state_d     = CHECK;
            out_valid_d = 1'b1;
            out_data_d  = sum_q;
            out_addr_d  = ADDR_ZERO;
            out_last_d  = 1'b1;
`else
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
            state_d   = FETCH;
          end
        end else begin
          state_d = SEND;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CHECK: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = CHECK;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        rd_addr_d   = ADDR_ZERO;
        out_valid_d = 1'b0;
        out_data_d  = DATA_ZERO;
        out_addr_d  = ADDR_ZERO;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= ADDR_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= DATA_ZERO;
      out_addr_q  <= ADDR_ZERO;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q       <= DATA_ZERO;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rd_addr        = rd_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_addr  = out_addr_q;
  assign strm.out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: register file model, ready patterns, timing/beat reference model.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  localparam int DW = REG_DATA_WIDTH;
  localparam int AW = REG_ADDR_WIDTH;
  localparam int N  = REG_COUNT;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  regfile_dump_reader_if s_if ();

  regfile_dump_reader dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .strm    (s_if.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] regs [N];
  assign rd_data = regs[rd_addr];

  bit            rdy [256];
  logic [DW-1:0] exp_data [NB];
  logic [AW-1:0] exp_addr [NB];
  logic          exp_last [NB];
  int            n_assert = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: beats are the registers in address order (plus checksum);
  // a register beat needs one fetch edge then waits for a ready edge.
  task automatic model(output int t_final);
    int t;
    int e;
    logic [DW-1:0] sum;
    t = 0;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      e = t + 2;
      while (!rdy[e]) e++;
      exp_addr[i] = AW'(i);
      exp_data[i] = regs[i];
      sum = sum + regs[i];
`ifdef DUMP_CHECKSUM_EN
      exp_last[i] = 1'b0;
`else
      exp_last[i] = (i == N - 1);
`endif
      t = e;
    end
`ifdef DUMP_CHECKSUM_EN
    e = t + 1;
    while (!rdy[e]) e++;
    exp_addr[N] = '0;
    exp_data[N] = sum;
    exp_last[N] = 1'b1;
    t = e;
`endif
    t_final = t;
  endtask

  task automatic set_rdy_all();
    for (int i = 0; i < 256; i++) rdy[i] = 1'b1;
  endtask

  task automatic preload_default();
    for (int i = 0; i < N - 1; i++) regs[i] = DW'(i);
    regs[N-1] = 8'hA5;
  endtask

  // One dump from a start pulse; checks busy/done every cycle, beat order and hold stability.
  task automatic run_dump(input string name, input int inject_edge);
    int tf;
    int got;
    bit hold;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_addr;
    logic p_last;
    model(tf);
    got = 0;
    hold = 1'b0;
    p_data = '0; p_addr = '0; p_last = 1'b0;
    @(negedge clk);
    start = 1'b1;
    s_if.out_ready = rdy[0];
    for (int e = 0; e <= tf + 1; e++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, " busy"}, 32'(busy), 32'(e < tf));
      check({name, " done"}, 32'(done), 32'(e == tf));
      if (hold) begin
        check({name, " hold_valid"}, 32'(s_if.out_valid), 32'd1);
        check({name, " hold_data"}, 32'(s_if.out_data), 32'(p_data));
        check({name, " hold_addr"}, 32'(s_if.out_addr), 32'(p_addr));
        check({name, " hold_last"}, 32'(s_if.out_last), 32'(p_last));
      end
      if (s_if.out_valid && rdy[e+1]) begin
        if (got < NB) begin
          check({name, " beat_addr"}, 32'(s_if.out_addr), 32'(exp_addr[got]));
          check({name, " beat_data"}, 32'(s_if.out_data), 32'(exp_data[got]));
          check({name, " beat_last"}, 32'(s_if.out_last), 32'(exp_last[got]));
        end
        got++;
        hold = 1'b0;
      end else begin
        hold = s_if.out_valid;
      end
      p_data = s_if.out_data;
      p_addr = s_if.out_addr;
      p_last = s_if.out_last;
      start = (e + 1 == inject_edge);
      s_if.out_ready = rdy[e+1];
    end
    check({name, " beat_count"}, 32'(got), 32'(NB));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    s_if.out_ready = 1'b0;
    preload_default();
    set_rdy_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(s_if.out_valid), 32'd0);
    check("rst out_data", 32'(s_if.out_data), 32'd0);
    check("rst out_addr", 32'(s_if.out_addr), 32'd0);
    check("rst out_last", 32'(s_if.out_last), 32'd0);
    check("rst rd_addr", 32'(rd_addr), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle no start busy", 32'(busy), 32'd0);

    // Basic dump followed back-to-back by an identical one.
    run_dump("basic", -1);
    run_dump("b2b", -1);

    // Five stalled cycles on the addr 3 beat (handshake would be edge 8).
    for (int i = 8; i < 13; i++) rdy[i] = 1'b0;
    run_dump("stall", -1);
    set_rdy_all();

    // Restart attempt while addr 2 is being fetched.
    run_dump("restart", 4);

    // Reset while the addr 4 beat is stalled in SEND.
    for (int i = 10; i < 256; i++) rdy[i] = 1'b0;
    @(negedge clk);
    start = 1'b1;
    s_if.out_ready = rdy[0];
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      s_if.out_ready = rdy[e+1];
    end
    check("pre_rst valid", 32'(s_if.out_valid), 32'd1);
    check("pre_rst addr", 32'(s_if.out_addr), 32'd4);
    check("pre_rst busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    s_if.out_ready = 1'b1;
    check("mid_rst valid", 32'(s_if.out_valid), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst rd_addr", 32'(rd_addr), 32'd0);
    check("mid_rst out_addr", 32'(s_if.out_addr), 32'd0);
    check("mid_rst out_last", 32'(s_if.out_last), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("mid_rst done", 32'(done), 32'd0);
      @(negedge clk);
    end
    set_rdy_all();
    run_dump("after_rst", -1);

    // Randomized register contents and back-pressure.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) regs[i] = DW'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) rdy[i] = (i >= 100) || ($urandom_range(0, 2) != 0);
      run_dump("random", (it % 2 == 0) ? int'($urandom_range(2, 15)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
